// File: rtl/clk_step_ctrl.sv
// rtl/clk_step_ctrl.sv - run/stop/step/burst CPU clock-enable sequencer with debounced buttons
// Optional burst mode compiled in when CLK_CTRL_BURST_EN is defined.
module clk_step_ctrl #(
  parameter int DEB_TICKS = 4,
  parameter int CW        = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          tick,
  input  logic          btn_run,
  input  logic          btn_stop,
  input  logic          btn_step,
  input  logic          btn_burst,
  input  logic [15:0]   burst_len,
  input  logic          brk,
  output logic          cpu_en,
  output logic [2:0]    clk_stat,
  output logic [CW-1:0] cyc_cnt,
  output logic          busy
);
  localparam int DW = $clog2(DEB_TICKS + 1);

  typedef enum logic [2:0] {
    S_STOP  = 3'd0,
    S_RUN   = 3'd1,
    S_STEP  = 3'd2,
    S_BURST = 3'd3,
    S_BRK   = 3'd4
  } state_t;

  // Button vector ordered by priority: [0] stop, [1] run, [2] step, [3] burst.
  logic [3:0]    btn_raw;
  logic [3:0]    sync1_q, sync2_q, lvl_q, lvl_prev_q;
  logic [DW-1:0] deb_cnt_q [4];
  logic [3:0]    press, cmd;
  state_t        state_q, state_d;
  logic          cpu_en_q, cpu_en_d;
  logic          brk_q, brk_rise;
  logic [CW-1:0] cyc_q;

`ifdef CLK_CTRL_BURST_EN
  logic [15:0]   rem_q, rem_d;
  assign btn_raw = {btn_burst, btn_step, btn_run, btn_stop};
`else
  logic          unused_burst;
  assign btn_raw      = {1'b0, btn_step, btn_run, btn_stop};
  assign unused_burst = ^{btn_burst, burst_len, cmd[3]};
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      lvl_q      <= '0;
      lvl_prev_q <= '0;
      for (int i = 0; i < 4; i++) deb_cnt_q[i] <= '0;
    end else begin
      sync1_q    <= btn_raw;
      sync2_q    <= sync1_q;
      lvl_prev_q <= lvl_q;
      if (tick) begin
        for (int i = 0; i < 4; i++) begin
          if (sync2_q[i] != lvl_q[i]) begin
            if (deb_cnt_q[i] == DW'(DEB_TICKS - 1)) begin
              lvl_q[i]     <= sync2_q[i];
              deb_cnt_q[i] <= '0;
            end else begin
              deb_cnt_q[i] <= deb_cnt_q[i] + 1'b1;
            end
          end else begin
            deb_cnt_q[i] <= '0;
          end
        end
      end
    end
  end

  assign press    = lvl_q & ~lvl_prev_q;
  assign brk_rise = brk & ~brk_q;

  // Only the highest-priority press survives; simultaneous lower ones are dropped.
  always_comb begin
    cmd = 4'b0000;
    if      (press[0]) cmd = 4'b0001;
    else if (press[1]) cmd = 4'b0010;
    else if (press[2]) cmd = 4'b0100;
    else if (press[3]) cmd = 4'b1000;
  end

  always_comb begin
    state_d = state_q;
`ifdef CLK_CTRL_BURST_EN
    rem_d   = rem_q;
`endif
    case (state_q)
      S_STOP: begin
        if      (cmd[1]) state_d = S_RUN;
        else if (cmd[2]) state_d = S_STEP;
`ifdef CLK_CTRL_BURST_EN
        else if (cmd[3] && (burst_len != 16'd0)) begin
          state_d = S_BURST;
          rem_d   = burst_len;
        end
`endif
      end
      S_RUN: begin
        if      (cmd[0])   state_d = S_STOP;
        else if (brk_rise) state_d = S_BRK;
      end
      S_STEP: state_d = S_STOP;
`ifdef CLK_CTRL_BURST_EN
      S_BURST: begin
        rem_d = rem_q - 16'd1;
        if      (cmd[0])           state_d = S_STOP;
        else if (brk_rise)         state_d = S_BRK;
        else if (rem_q == 16'd1)   state_d = S_STOP;
      end
`endif
      S_BRK: begin
        if      (cmd[0]) state_d = S_STOP;
        else if (cmd[1]) state_d = S_RUN;
        else if (cmd[2]) state_d = S_STEP;
      end
      default: state_d = S_STOP;
    endcase
    cpu_en_d = (state_d == S_RUN) || (state_d == S_STEP) || (state_d == S_BURST);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_STOP;
      cpu_en_q <= 1'b0;
      brk_q    <= 1'b0;
      cyc_q    <= '0;
`ifdef CLK_CTRL_BURST_EN
      rem_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cpu_en_q <= cpu_en_d;
      brk_q    <= brk;
      cyc_q    <= cyc_q + CW'(cpu_en_q);
`ifdef CLK_CTRL_BURST_EN
      rem_q    <= rem_d;
`endif
    end
  end

  assign cpu_en   = cpu_en_q;
  assign clk_stat = state_q;
  assign cyc_cnt  = cyc_q;
  assign busy     = (state_q != S_STOP) && (state_q != S_BRK);
endmodule

// File: tb/tb_clk_step_ctrl.sv
// tb/tb_clk_step_ctrl.sv - scoreboard bench for clk_step_ctrl
module tb_clk_step_ctrl;
  localparam int CW  = 8;
  localparam int DEB = 4;
  localparam logic [2:0] ST_STOP = 3'd0, ST_RUN = 3'd1, ST_STEP = 3'd2, ST_BURST = 3'd3, ST_BRK = 3'd4;

  logic clk = 1'b0, reset = 1'b0, tick = 1'b0, brk = 1'b0;
  logic btn_run = 1'b0, btn_stop = 1'b0, btn_step = 1'b0, btn_burst = 1'b0;
  logic [15:0] burst_len = 16'd0;
  logic cpu_en, busy;
  logic [2:0] clk_stat;
  logic [CW-1:0] cyc_cnt;

  clk_step_ctrl #(.DEB_TICKS(DEB), .CW(CW)) dut (
    .clk(clk), .reset(reset), .tick(tick),
    .btn_run(btn_run), .btn_stop(btn_stop), .btn_step(btn_step), .btn_burst(btn_burst),
    .burst_len(burst_len), .brk(brk),
    .cpu_en(cpu_en), .clk_stat(clk_stat), .cyc_cnt(cyc_cnt), .busy(busy)
  );

  initial forever #5 clk = ~clk;

  initial begin
    int tc;
    tc = 0;
    forever begin
      @(negedge clk);
      tick = (tc == 9);
      tc = (tc == 9) ? 0 : tc + 1;
    end
  end

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic bit en_mode(input logic [2:0] s);
    return (s == ST_RUN) || (s == ST_STEP) || (s == ST_BURST);
  endfunction

  // Scoreboard: each entry is a mode the DUT must enter next and how long it must stay (-1 = open).
  typedef struct { logic [2:0] stat; int len; } exp_t;
  exp_t sbq[$];
  logic [2:0] seen_stat, exp_stat;
  int n_in, exp_len;
  logic [CW-1:0] base;

  task automatic push(input logic [2:0] s, input int len);
    exp_t e;
    e.stat = s;
    e.len  = len;
    sbq.push_back(e);
  endtask

  initial begin
    exp_t e;
    logic [CW-1:0] exp_c;
    forever begin
      @(negedge clk);
      if (!reset) begin
        seen_stat = ST_STOP; exp_stat = ST_STOP; n_in = 0; exp_len = -1; base = '0;
      end else begin
        if (clk_stat !== seen_stat) begin
          if (exp_len >= 0) check("mode_length", n_in, exp_len);
          if (en_mode(exp_stat)) base = base + CW'(n_in);
          n_in = 0;
          seen_stat = clk_stat;
          if (sbq.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_mode_change: got %0d expected %0d", clk_stat, exp_stat);
            exp_len = -1;
          end else begin
            e = sbq.pop_front();
            check("mode", clk_stat, e.stat);
            exp_stat = e.stat;
            exp_len  = e.len;
          end
        end
        exp_c = base + (en_mode(exp_stat) ? CW'(n_in) : CW'(0));
        check("cpu_en", cpu_en, en_mode(exp_stat));
        check("busy", busy, en_mode(exp_stat));
        check("cyc_cnt", cyc_cnt, exp_c);
        n_in++;
      end
    end
  end

  // Reference model of the mode machine at the level of button presses.
  logic [2:0] mmode = ST_STOP;

  task automatic model_press(input logic [3:0] m);
    logic [3:0] mm;
    mm = m;
`ifndef CLK_CTRL_BURST_EN
    mm[3] = 1'b0;
`endif
    if (mm[0]) mm = 4'b0001;
    else if (mm[1]) mm = 4'b0010;
    else if (mm[2]) mm = 4'b0100;
    case (mmode)
      ST_STOP: begin
        if (mm[1]) begin push(ST_RUN, -1); mmode = ST_RUN; end
        else if (mm[2]) begin push(ST_STEP, 1); push(ST_STOP, -1); end
        else if (mm[3] && burst_len != 16'd0) begin push(ST_BURST, int'(burst_len)); push(ST_STOP, -1); end
      end
      ST_RUN: if (mm[0]) begin push(ST_STOP, -1); mmode = ST_STOP; end
      ST_BRK: begin
        if (mm[0]) begin push(ST_STOP, -1); mmode = ST_STOP; end
        else if (mm[1]) begin push(ST_RUN, -1); mmode = ST_RUN; end
        else if (mm[2]) begin push(ST_STEP, 1); push(ST_STOP, -1); mmode = ST_STOP; end
      end
      default: ;
    endcase
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [3:0] m);
    btn_stop = m[0]; btn_run = m[1]; btn_step = m[2]; btn_burst = m[3];
    cycles(60);
    btn_stop = 1'b0; btn_run = 1'b0; btn_step = 1'b0; btn_burst = 1'b0;
    cycles(60);
  endtask

  task automatic drain(input int budget);
    int t;
    t = 0;
    while (sbq.size() != 0 && t < budget) begin
      @(negedge clk);
      t++;
    end
    check("queue_drained", sbq.size(), 0);
  endtask

  task automatic do_press(input logic [3:0] m);
    model_press(m);
    press(m);
    drain(600);
  endtask

  task automatic brk_rise(input int hold);
    if (mmode == ST_RUN) begin push(ST_BRK, -1); mmode = ST_BRK; end
    brk = 1'b1;
    cycles(hold);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int need, t;
    #1;
    check("rst_cpu_en", cpu_en, 0);
    check("rst_clk_stat", clk_stat, 0);
    check("rst_cyc_cnt", cyc_cnt, 0);
    check("rst_busy", busy, 0);
    cycles(5);
    reset = 1'b1;
    cycles(5);

    repeat (3) begin
      btn_step = 1'b1; cycles(3);
      btn_step = 1'b0; cycles(27);
    end
    do_press(4'b0100);
    check("step_cyc_cnt", cyc_cnt, 1);

    do_press(4'b0010);
    cycles(100);
    do_press(4'b0001);

    burst_len = 16'd5;
    do_press(4'b1000);
    burst_len = 16'd0;
    do_press(4'b1000);

    do_press(4'b0010);
    cycles(30);
    brk_rise(20);
    do_press(4'b0010);
    cycles(80);
    brk = 1'b0;
    cycles(5);
    brk_rise(10);
    do_press(4'b0001);
    brk = 1'b0;

    do_press(4'b0010);
    do_press(4'b0011);
    do_press(4'b0101);

    for (int it = 0; it < 30; it++) begin
      case ($urandom_range(0, 3))
        0, 1: begin
          burst_len = 16'($urandom_range(0, 20));
          do_press(4'($urandom_range(1, 15)));
        end
        2: begin
          brk_rise(5);
          brk = 1'b0;
          cycles(5);
          drain(50);
        end
        default: cycles($urandom_range(1, 80));
      endcase
    end

    do_press(4'b0001);
    cycles(5);
`ifdef CLK_CTRL_BURST_EN
    need = (1 << CW) - 1 - int'(base);
    if (need > 0) begin
      burst_len = 16'(need);
      do_press(4'b1000);
    end
    do_press(4'b0100);
    check("cyc_cnt_wrap", cyc_cnt, 0);
    burst_len = 16'd1000;
    push(ST_BURST, -1);
    press(4'b1000);
`else
    push(ST_RUN, -1);
    press(4'b0010);
`endif
    t = 0;
    while (!(en_mode(exp_stat) && n_in >= 300) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check("reached_enable_300", t < 2000, 1);
    #3 reset = 1'b0;
    #1;
    check("async_rst_cpu_en", cpu_en, 0);
    check("async_rst_clk_stat", clk_stat, 0);
    check("async_rst_cyc_cnt", cyc_cnt, 0);
    check("async_rst_busy", busy, 0);
    check("queue_empty_at_reset", sbq.size(), 0);
    cycles(4);
    reset = 1'b1;
    mmode = ST_STOP;
    cycles(5);
    do_press(4'b0100);
    check("post_reset_step_cyc", cyc_cnt, 1);
    cycles(10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
